// File: rtl/key_pkg.sv
// Shared types and defaults for the key debouncer.
`timescale 1ns/1ps
package key_pkg;

  // 20 ms filter at 50 MHz, expressed as cycles minus one.
  localparam int CNT_MAX_DEFAULT = 999_999;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILTER_DN = 2'd1,
    DOWN      = 2'd2,
    FILTER_UP = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw key; resets to the released level (1).
`timescale 1ns/1ps
module key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Key debouncer: synchronizer, four-state filter FSM, registered press flag,
// debounced level and a toggling active-low LED.
`timescale 1ns/1ps
module key_debounce
  import key_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_flag,
  output logic       key_state,
  output logic       led_out,
  output fsm_state_t dbg_state
);

  localparam int CW = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);

  logic          key_s;
  fsm_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          flag_nxt, key_state_nxt, led_nxt;

  key_sync u_sync (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (key_in),
    .q   (key_s)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      key_flag  <= 1'b0;
      key_state <= 1'b1;
      led_out   <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_flag  <= flag_nxt;
      key_state <= key_state_nxt;
      led_out   <= led_nxt;
    end
  end

  // A filter state falls back to its stable state on any contrary sample,
  // so only an unbroken run of CNT_MAX+2 samples changes the level.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    flag_nxt      = 1'b0;
    key_state_nxt = key_state;
    led_nxt       = led_out;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = FILTER_DN;
          cnt_nxt   = '0;
        end
      end
      FILTER_DN: begin
        if (key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt     = DOWN;
          cnt_nxt       = '0;
          flag_nxt      = 1'b1;
          key_state_nxt = 1'b0;
          led_nxt       = ~led_out;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DOWN: begin
        if (key_s) begin
          state_nxt = FILTER_UP;
          cnt_nxt   = '0;
        end
      end
      FILTER_UP: begin
        if (!key_s) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          key_state_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce with CNT_MAX=4: table rows, latency/reset sequences,
// bounce and random stimulus against a run-length reference model.
`timescale 1ns/1ps
module tb_key_debounce;
  import key_pkg::*;

  localparam int CNT_MAX = 4;
  localparam int RUN     = CNT_MAX + 2;

  // clock / reset
  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       key_in;
  logic       key_flag;
  logic       key_state;
  logic       led_out;
  fsm_state_t dbg_state;

  always #10 sys_clk = ~sys_clk;

  key_debounce #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .led_out   (led_out),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  int flag_total;
  int model_flags;

  // Reference: the level flips after RUN consecutive opposing samples of the
  // key delayed by two edges; a flip to pressed pulses the flag and the LED.
  bit m_level, m_led, m_flag;
  int m_run;
  bit m_dly[$];

  function void model_reset();
    m_level = 1'b1;
    m_led   = 1'b1;
    m_flag  = 1'b0;
    m_run   = 0;
    m_dly.delete();
    m_dly.push_back(1'b1);
    m_dly.push_back(1'b1);
  endfunction

  function void model_edge(input bit k);
    bit s;
    s = m_dly.pop_front();
    m_dly.push_back(k);
    m_flag = 1'b0;
    if (s != m_level) m_run++;
    else m_run = 0;
    if (m_run == RUN) begin
      m_level = s;
      m_run   = 0;
      if (!s) begin
        m_flag = 1'b1;
        m_led  = ~m_led;
        model_flags++;
      end
    end
  endfunction

  function fsm_state_t model_state();
    if (m_level) return (m_run == 0) ? IDLE : FILTER_DN;
    else         return (m_run == 0) ? DOWN : FILTER_UP;
  endfunction

  // scoreboard
  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name, input fsm_state_t exp);
    n_cmp++;
    if (dbg_state !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, dbg_state, exp, $time);
    end
  endtask

  task automatic check_model();
    check_bit("model_flag", key_flag, m_flag);
    check_bit("model_key_state", key_state, m_level);
    check_bit("model_led", led_out, m_led);
    check_state("model_state", model_state());
  endtask

  // drivers
  task automatic tick(input bit k);
    key_in = k;
    @(posedge sys_clk);
    model_edge(k);
    #1;
    if (key_flag === 1'b1) flag_total++;
    check_model();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    #2;
    model_reset();
    check_bit("rst_flag", key_flag, 1'b0);
    check_bit("rst_key_state", key_state, 1'b1);
    check_bit("rst_led", led_out, 1'b1);
    check_state("rst_state", IDLE);
    @(posedge sys_clk);
    #1;
    sys_rst     = 1'b0;
    flag_total  = 0;
    model_flags = 0;
  endtask

  typedef struct {
    int low1;
    int high;
    int low2;
    int exp_flags;
    bit exp_state;
    bit exp_led;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowrun;
    bit r1, r2, lvl;
    int len;

    tbl[0] = '{5,   10, 0,  0, 1'b1, 1'b1};
    tbl[1] = '{6,   10, 0,  1, 1'b1, 1'b0};
    tbl[2] = '{3,   10, 0,  0, 1'b1, 1'b1};
    tbl[3] = '{100, 10, 10, 2, 1'b0, 1'b1};
    tbl[4] = '{20,  5,  10, 1, 1'b0, 1'b0};
    tbl[5] = '{20,  6,  10, 2, 1'b0, 1'b1};
    tbl[6] = '{7,   1,  7,  1, 1'b0, 1'b0};
    tbl[7] = '{0,   10, 0,  0, 1'b1, 1'b1};

    sys_rst = 1'b1;
    key_in  = 1'b1;
    #5;
    do_reset();

    // table rows: low run, high run, low run, then final outcome
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < tbl[r].low1; i++) tick(1'b0);
      for (int i = 0; i < tbl[r].high; i++) tick(1'b1);
      for (int i = 0; i < tbl[r].low2; i++) tick(1'b0);
      check_int($sformatf("row%0d_flags", r), flag_total, tbl[r].exp_flags);
      check_bit($sformatf("row%0d_key_state", r), key_state, tbl[r].exp_state);
      check_bit($sformatf("row%0d_led", r), led_out, tbl[r].exp_led);
    end

    // exact latency: six low samples, flag only after edge 7
    do_reset();
    for (int k = 0; k < 13; k++) begin
      tick((k < 6) ? 1'b0 : 1'b1);
      check_bit($sformatf("lat_flag_e%0d", k), key_flag, k == 7);
      check_bit($sformatf("lat_key_state_e%0d", k), key_state, k < 7);
      check_bit($sformatf("lat_led_e%0d", k), led_out, k < 7);
    end

    // reset while pressed, then reset mid-filter with key held low
    do_reset();
    for (int k = 0; k < 20; k++) tick(1'b0);
    check_state("pressed_state", DOWN);
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0);
    check_state("mid_filter_state", FILTER_DN);
    do_reset();
    for (int k = 0; k < 11; k++) begin
      tick(1'b0);
      check_bit($sformatf("rst_refilter_flag_e%0d", k), key_flag, k == 7);
    end

    // bounce at half-clock rate for 1 us, never more than 4 sampled lows in a row
    do_reset();
    lowrun = 0;
    for (int k = 0; k < 50; k++) begin
      r1 = 1'($urandom_range(0, 1));
      key_in = r1;
      @(negedge sys_clk);
      r2 = 1'($urandom_range(0, 1));
      if (!r2 && lowrun >= 4) r2 = 1'b1;
      lowrun = r2 ? 0 : lowrun + 1;
      key_in = r2;
      @(posedge sys_clk);
      model_edge(r2);
      #1;
      if (key_flag === 1'b1) flag_total++;
      check_model();
    end
    check_int("bounce_flags", flag_total, 0);
    check_bit("bounce_key_state", key_state, 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0);
    check_int("stable_after_bounce_flags", flag_total, 1);
    check_bit("stable_after_bounce_key_state", key_state, 1'b0);

    // random runs of varying length against the model
    do_reset();
    lvl = 1'b1;
    for (int seg = 0; seg < 80; seg++) begin
      lvl = ~lvl;
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) tick(lvl);
    end
    check_int("random_flag_count", flag_total, model_flags);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CNT_MAX, default 999_999 (20 ms at 50 MHz), filter length in clock cycles minus one; legal range ≥1.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 sys_clk  input  1  system clock; all state on its rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  1  raw, bouncing, asynchronous key; 0 = pressed, 1 = released.
REQ-006 key_flag  output  1  one-cycle pulse per confirmed press.
REQ-007 key_state  output  1  debounced key level; 0 = pressed, 1 = released.
REQ-008 led_out  output  1  LED drive, active-low (0 = lit); toggles on each confirmed press.

Function
REQ-009 key_in SHALL pass through a two-flop synchronizer; key_s = second flop; no other logic reads key_in.
REQ-010 FSM states SHALL be IDLE (released, stable), FILTER_DN, DOWN (pressed, stable), FILTER_UP.
REQ-011 IDLE: key_s=0 -> FILTER_DN, cnt<=0; else stay.
REQ-012 FILTER_DN: key_s=1 -> IDLE, cnt<=0 (bounce rejected, no output change); key_s=0 and cnt<CNT_MAX -> cnt<=cnt+1; key_s=0 and cnt==CNT_MAX -> DOWN, cnt<=0.
REQ-013 DOWN: key_s=1 -> FILTER_UP, cnt<=0; else stay.
REQ-014 FILTER_UP: key_s=0 -> DOWN, cnt<=0; key_s=1 and cnt<CNT_MAX -> cnt<=cnt+1; key_s=1 and cnt==CNT_MAX -> IDLE, cnt<=0.
REQ-015 cnt SHALL be $clog2(CNT_MAX+1) bits, unsigned, never exceeding CNT_MAX; it never wraps.
REQ-016 On the FILTER_DN->DOWN edge, key_flag<=1, key_state<=0 and led_out<=~led_out; key_flag SHALL be 0 on every other cycle.
REQ-017 On the FILTER_UP->IDLE edge, key_state<=1; no flag, no LED change.
REQ-018 All outputs SHALL be registered; no combinational path from key_in to any output.
REQ-019 Latency: with edge e0 the first edge sampling key_in=0 from IDLE, key_in held 0 at e0..e(CNT_MAX+1) SHALL make key_flag high exactly in the cycle after e(CNT_MAX+3); any 1 sampled in that window yields no flag.
REQ-020 A held press SHALL produce exactly one key_flag regardless of hold duration.
REQ-021 Release bounce shorter than CNT_MAX+2 samples SHALL NOT produce a second flag or alter key_state.

Reset
REQ-022 sys_rst=1 SHALL asynchronously force state=IDLE, cnt=0, synchronizer flops=1, key_flag=0, key_state=1, led_out=1.
REQ-023 Reset asserted mid-filter or in DOWN SHALL discard progress; after release, a still-held key SHALL require a full new filter window before key_flag.

Structure
REQ-024 Shared package key_pkg SHALL hold the FSM state typedef (IDLE, FILTER_DN, DOWN, FILTER_UP) and the default CNT_MAX constant.
REQ-025 One sub-module key_sync (two-flop synchronizer, reset value 1) SHALL be instantiated; the FSM, counter and outputs stay in key_debounce.

Verification (CNT_MAX=4, 20 ns clock)
REQ-026 Reset pulse mid-run -> immediately key_flag=0, key_state=1, led_out=1; state IDLE.
REQ-027 key_in low for 5 sampled edges then high -> no key_flag, key_state stays 1, led_out stays 1.
REQ-028 key_in low for 6 sampled edges from e0 -> key_flag high only in the cycle after e7; key_state=0 and led_out=0 from then.
REQ-029 key_in held low 100 cycles, then high 10 cycles, then low 10 cycles -> two key_flag pulses total; led_out back to 1; key_state ends 0.
REQ-030 Random key_in toggle every 10 ns (bounce) for 1 µs, then stable low -> no flag during bounce; exactly one flag after the stable window.
REQ-031 Reset asserted 3 cycles into FILTER_DN with key_in held low -> flag appears only CNT_MAX+4 edges after reset release.
